spi_cfg_sequencer: RTL and testbench
====================================

// Module: spi_cfg_sequencer
// PURPOSE
//  Write-side sequencer for the on-chip SPI configuration register bank (regs 0..4).
//  Arbitrates register-write requests from NUM_REQ requesters, round-robin.
//  Serialises each granted write as one SPI write frame on nCS/COPI.
//  Rejects out-of-range addresses without generating a frame.
// PARAMETERS
//  NUM_REQ     2  number of requester ports (2..4)
//  ADDR_W      7  register address width in frame
//  DATA_W      8  register data width in frame
//  MAX_ADDR    4  highest valid register address
//  GAP_CYCLES  2  idle SCLK cycles with nCS high between frames (>=1)
// PORTS
//  SCLK      in   1               serial clock; all logic on rising edge
//  rst_n     in   1               asynchronous, active-low reset
//  req_i     in   NUM_REQ         per-requester write request, level, held until ack
//  addr_i    in   NUM_REQ*ADDR_W  packed addresses, slice k belongs to req k
//  data_i    in   NUM_REQ*DATA_W  packed data, slice k belongs to req k
//  ack_o     out  NUM_REQ         one-cycle grant pulse; addr/data captured
//  err_o     out  1               one-cycle pulse with ack when address > MAX_ADDR
//  nCS       out  1               chip select to SPI register bank, active low
//  COPI      out  1               serial data, MSB first, registered
//  busy_o    out  1               high whenever state != IDLE
//  done_o    out  1               one-cycle pulse on the cycle nCS returns high
// BEHAVIOUR
//  Reset: nCS=1, COPI=0, ack_o=0, err_o=0, busy_o=0, done_o=0, rr pointer=NUM_REQ-1.
//  Reset mid-frame: frame dropped, nCS high on assertion; no ack or done emitted.
//  Frame (16 bits): {1'b1 (W), addr[6:0], data[7:0]}; bit 15 shifted first.
//  States:
//   IDLE   : any req_i set -> grant; ack_o[g]=1 in the same cycle.
//            Address valid -> load shift reg -> CS_SETUP.
//            Address invalid -> err_o=1, no frame -> GAP.
//   CS_SETUP: nCS=0, COPI=0 for 1 cycle -> SHIFT.
//   SHIFT  : 16 cycles, COPI=frame[15-cnt], nCS=0; after cnt=15 -> HOLD.
//   HOLD   : nCS=1, COPI=0, done_o=1 for 1 cycle -> GAP.
//   GAP    : nCS=1 for GAP_CYCLES-1 further cycles -> IDLE; requests ignored.
//  Latency: ack to first nCS low = 1 cycle. Frame = 1+16+1 cycles.
//           Next grant no earlier than GAP_CYCLES after done.
//  Arbitration: search starts at ptr+1 mod NUM_REQ; the first set req wins.
//   ptr <- winner on every grant, including rejected ones.
//   Simultaneous reqs: exactly one ack per grant cycle.
//  Handshake: requester holds req/addr/data stable until ack.
//   Requester deasserts req the cycle after ack, or re-requests.
//   A req dropped before ack is permitted and produces no frame.
//  Counters: 4-bit bit counter; GAP counter sized $clog2(GAP_CYCLES+1).
//   Neither counter wraps; both are reloaded on state entry.
//  Outputs are registered; no combinational path from req_i to nCS/COPI.
//   ack_o and err_o are decoded from the arbiter in IDLE.
// STRUCTURE
//  Package spi_cfg_pkg:
//   state encoding IDLE/CS_SETUP/SHIFT/HOLD/GAP
//   FRAME_W=16, WBIT_POS=15, MAX_ADDR, ADDR_W, DATA_W
//  Sub-module rr_arbiter:
//   NUM_REQ-wide round-robin grant, one-hot output
//   ptr update on grant-enable input
//  Top holds the FSM, shift register, counters and the output registers.
// TESTING
//  1. Reset, req_i=0 for 10 cycles -> nCS=1, COPI=0, busy_o=0, all pulses 0.
//  2. req0, addr=2, data=0xA5 -> ack_o=01 one cycle; nCS low 17 cycles.
//     COPI 1,0000010,10100101; done_o one cycle after.
//     A peripheral-model bench shows reg2=0xA5.
//  3. req0 and req1 together, ptr=1 after reset -> req0 frame first.
//     GAP_CYCLES later req1 frame; ack order 01 then 10.
//  4. req1, addr=5 -> ack_o=10 with err_o=1, nCS stays high, no done_o.
//     A following valid req is granted after GAP.
//  5. rst_n low at SHIFT bit 8 -> nCS=1 at once, no done_o.
//     After release, a new req yields a complete clean frame.
//  6. Both reqs held for 4 frames -> grants alternate 0,1,0,1.
//     Inter-frame nCS-high time = GAP_CYCLES+1.

Source files
------------

// File: rtl/spi_cfg_sequencer_pkg.sv
// Shared types and constants for the SPI configuration-register write sequencer.
package spi_cfg_pkg;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int MAX_ADDR = 4;
    localparam int FRAME_W  = 16;
    localparam int WBIT_POS = 15;
    localparam int BITCNT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        HOLD     = 3'd3,
        GAP      = 3'd4
    } state_e;

    // Write frame: write flag in the MSB, then address, then data.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {1'b1, addr, data};
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
        return (addr <= ADDR_W'(MAX_ADDR));
    endfunction

endpackage

// File: rtl/spi_cfg_sequencer_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               SCLK,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   win_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic               found_s;

    // Pick the first set request after the pointer and update the pointer on a grant.
    always_comb begin
        gnt_s   = '0;
        win_s   = ptr_q;
        found_s = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found_s && req_i[(int'(ptr_q) + i) % NUM_REQ]) begin
                gnt_s[(int'(ptr_q) + i) % NUM_REQ] = 1'b1;
                win_s   = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        if (en_i && found_s) begin
            ptr_d = win_s;
            gnt_o = gnt_s;
        end else begin
            ptr_d = ptr_q;
            gnt_o = '0;
        end
    end

    // Pointer register; after reset the search starts at requester 0.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PTR_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Arbitrates register writes and serialises each one as a 16-bit SPI write frame.
module spi_cfg_sequencer
    import spi_cfg_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                      SCLK,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      err_o,
    output logic                      nCS,
    output logic                      COPI,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  sh_q, sh_d;
    logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                ncs_q, ncs_d;
    logic                copi_q, copi_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic                arb_en_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                err_s;

    assign arb_en_s = (state_q == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .SCLK  (SCLK),
        .rst_n (rst_n),
        .req_i (req_i),
        .en_i  (arb_en_s),
        .gnt_o (gnt_s)
    );

    // Mux the granted requester's address and data (grant is one-hot).
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_addr_s = sel_addr_s | (addr_i[k*ADDR_W +: ADDR_W] & {ADDR_W{gnt_s[k]}});
            sel_data_s = sel_data_s | (data_i[k*DATA_W +: DATA_W] & {DATA_W{gnt_s[k]}});
        end
    end

    // Frame FSM: next state, shifter, counters, and the next values of the serial outputs.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        err_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_s != '0) begin
                    if (addr_in_range(sel_addr_s)) begin
                        sh_d    = build_frame(sel_addr_s, sel_data_s);
                        state_d = CS_SETUP;
                    end else begin
                        err_s   = 1'b1;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CS_SETUP: begin
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                sh_d = {sh_q[FRAME_W-2:0], 1'b0};
                if (bit_cnt_q == BITCNT_W'(FRAME_W - 1)) begin
                    state_d = HOLD;
                end else begin
                    bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
                end
            end
            HOLD: begin
                // HOLD already provides the first idle cycle of the inter-frame gap.
                if (GAP_CYCLES > 1) begin
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        ncs_d  = !((state_d == CS_SETUP) || (state_d == SHIFT));
        copi_d = (state_d == SHIFT) ? sh_d[WBIT_POS] : 1'b0;
        done_d = (state_d == HOLD);
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers; reset drops any frame in flight.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            gap_q     <= '0;
            ncs_q     <= 1'b1;
            copi_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            gap_q     <= gap_d;
            ncs_q     <= ncs_d;
            copi_q    <= copi_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    // ack/err are the arbiter decode in IDLE, so the requester sees them in the grant cycle.
    assign ack_o  = gnt_s;
    assign err_o  = err_s;
    assign nCS    = ncs_q;
    assign COPI   = copi_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Self-checking bench for spi_cfg_sequencer: requester models, frame monitor, scoreboard.
module tb_spi_cfg_sequencer;
    import spi_cfg_pkg::*;

    localparam int NR  = 2;
    localparam int AW  = 7;
    localparam int DW  = 8;
    localparam int GAP = 2;

    logic              SCLK = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_i;
    logic [NR*AW-1:0]  addr_i;
    logic [NR*DW-1:0]  data_i;
    logic [NR-1:0]     ack_o;
    logic              err_o, nCS, COPI, busy_o, done_o;

    always #5 SCLK = ~SCLK;

    spi_cfg_sequencer #(.NUM_REQ(NR), .GAP_CYCLES(GAP)) dut (
        .SCLK(SCLK), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .data_i(data_i),
        .ack_o(ack_o), .err_o(err_o), .nCS(nCS), .COPI(COPI), .busy_o(busy_o), .done_o(done_o)
    );

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } tx_t;
    typedef struct { logic [NR-1:0] ack; logic err; } gexp_t;
    typedef struct { int rq; logic [AW-1:0] addr; logic [DW-1:0] data;
                     logic [NR-1:0] exp_ack; logic exp_err; } vec_t;

    tx_t         txq[NR][$];
    gexp_t       gq[$];
    logic [15:0] fq[$];
    int          gaps_q[$];
    int          ack_cyc_q[$];
    logic [7:0]  regs [5];
    logic [7:0]  exp_regs [5];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    logic        mon_prev;
    int          mon_low, mon_hi;
    logic [15:0] mon_fr;
    logic        mon_cs_chk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_tx(int rq, logic [AW-1:0] a, logic [DW-1:0] d);
        tx_t t;
        t.addr = a;
        t.data = d;
        txq[rq].push_back(t);
    endtask

    task automatic push_exp(logic [NR-1:0] ack, logic err, logic [AW-1:0] a, logic [DW-1:0] d);
        gexp_t g;
        g.ack = ack;
        g.err = err;
        gq.push_back(g);
        if (!err) fq.push_back({1'b1, a, d});
    endtask

    task automatic wait_idle(string name);
        int  t;
        bit  idle;
        t    = 0;
        idle = 1'b0;
        while (!idle && t < 300) begin
            @(negedge SCLK); #1;
            t++;
            idle = (gq.size() == 0) && (txq[0].size() == 0) && (txq[1].size() == 0) &&
                   (busy_o === 1'b0) && (req_i == '0);
        end
        if (!idle) fail({name, "_timeout"}, 32'(t), 32'd300);
        @(negedge SCLK); #1;
    endtask

    always @(posedge SCLK) cyc <= cyc + 1;

    // Requester models: hold req/addr/data until ack, then load the next item or drop req.
    initial begin
        req_i  = '0;
        addr_i = '0;
        data_i = '0;
        forever begin
            @(posedge SCLK); #1;
            for (int k = 0; k < NR; k++) begin
                if (rst_n === 1'b1 && txq[k].size() > 0) begin
                    req_i[k] = 1'b1;
                    addr_i[k*AW +: AW] = txq[k][0].addr;
                    data_i[k*DW +: DW] = txq[k][0].data;
                end else begin
                    req_i[k] = 1'b0;
                end
            end
        end
    end

    // Monitor: grant scoreboard, frame capture, frame timing and a peripheral register model.
    initial begin
        gexp_t       e;
        logic [15:0] ef;
        mon_prev = 1'b1; mon_low = 0; mon_hi = 0; mon_fr = '0; mon_cs_chk = 1'b0;
        forever begin
            @(negedge SCLK);
            if (rst_n !== 1'b1) begin
                mon_prev = 1'b1; mon_low = 0; mon_hi = 0; mon_cs_chk = 1'b0;
            end else begin
                if (mon_cs_chk) begin
                    chk("cs_latency", 32'(nCS), 32'd0);
                    mon_cs_chk = 1'b0;
                end
                if (ack_o != '0 || err_o) begin
                    if (gq.size() == 0) begin
                        fail("unexpected_grant", {ack_o, err_o}, 32'd0);
                    end else begin
                        e = gq.pop_front();
                        chk("ack", 32'(ack_o), 32'(e.ack));
                        chk("err", 32'(err_o), 32'(e.err));
                        chk("busy_at_grant", 32'(busy_o), 32'd0);
                        mon_cs_chk = !e.err;
                    end
                    ack_cyc_q.push_back(cyc);
                    for (int k = 0; k < NR; k++)
                        if (ack_o[k] && txq[k].size() > 0) void'(txq[k].pop_front());
                end
                if (nCS === 1'b0) begin
                    if (mon_prev) begin
                        gaps_q.push_back(mon_hi);
                        mon_low = 0;
                    end
                    mon_low++;
                    if (mon_low == 1) chk("copi_setup", 32'(COPI), 32'd0);
                    else mon_fr = {mon_fr[14:0], COPI};
                end else begin
                    if (!mon_prev) begin
                        chk("ncs_low_len", 32'(mon_low), 32'd17);
                        chk("done_on_rise", 32'(done_o), 32'd1);
                        if (fq.size() == 0) begin
                            fail("unexpected_frame", 32'(mon_fr), 32'd0);
                        end else begin
                            ef = fq.pop_front();
                            chk("frame", 32'(mon_fr), 32'(ef));
                        end
                        if (mon_fr[15] && mon_fr[14:8] <= 7'd4) regs[mon_fr[10:8]] = mon_fr[7:0];
                        mon_hi = 0;
                    end else if (done_o !== 1'b0) begin
                        fail("spurious_done", 32'(done_o), 32'd0);
                    end
                    mon_hi++;
                end
                mon_prev = nCS;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vec_t vecs[7];
        int   t;
        bit   hit;

        vecs[0] = '{0, 7'd2,   8'hA5, 2'b01, 1'b0};
        vecs[1] = '{1, 7'd0,   8'h3C, 2'b10, 1'b0};
        vecs[2] = '{0, 7'd4,   8'hFF, 2'b01, 1'b0};
        vecs[3] = '{1, 7'd5,   8'h00, 2'b10, 1'b1};
        vecs[4] = '{0, 7'd127, 8'h12, 2'b01, 1'b1};
        vecs[5] = '{1, 7'd1,   8'h00, 2'b10, 1'b0};
        vecs[6] = '{0, 7'd3,   8'h81, 2'b01, 1'b0};
        for (int i = 0; i < 5; i++) begin regs[i] = 8'h00; exp_regs[i] = 8'h00; end

        // Reset state and a quiet idle period.
        rst_n = 1'b0;
        #12;
        chk("rst_ncs", 32'(nCS), 32'd1);
        chk("rst_copi", 32'(COPI), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        @(negedge SCLK); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge SCLK); #1;
            chk("idle_outputs", {ack_o, err_o, nCS, COPI, busy_o, done_o}, {2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        end

        // Simultaneous requests right after reset: requester 0 first, then 1.
        gaps_q.delete();
        push_tx(0, 7'd1, 8'h11);
        push_tx(1, 7'd2, 8'h22);
        push_exp(2'b01, 1'b0, 7'd1, 8'h11);
        push_exp(2'b10, 1'b0, 7'd2, 8'h22);
        wait_idle("simul");
        chk("simul_nframes", 32'(gaps_q.size()), 32'd2);
        if (gaps_q.size() == 2) chk("simul_gap", 32'(gaps_q[1]), 32'(GAP + 1));

        // Single-requester vectors, including range boundaries.
        for (int i = 0; i < 7; i++) begin
            push_tx(vecs[i].rq, vecs[i].addr, vecs[i].data);
            push_exp(vecs[i].exp_ack, vecs[i].exp_err, vecs[i].addr, vecs[i].data);
            if (!vecs[i].exp_err) exp_regs[vecs[i].addr[2:0]] = vecs[i].data;
            wait_idle("vec");
        end
        for (int i = 0; i < 5; i++) chk("periph_reg", 32'(regs[i]), 32'(exp_regs[i]));

        // Rejected address followed by a valid request: grant comes right after the gap.
        ack_cyc_q.delete();
        push_tx(1, 7'd5, 8'h77);
        push_exp(2'b10, 1'b1, 7'd5, 8'h77);
        t = 0;
        while (gq.size() != 0 && t < 50) begin @(negedge SCLK); #1; t++; end
        if (gq.size() != 0) fail("err_grant_timeout", 32'(t), 32'd50);
        push_tx(0, 7'd1, 8'h5A);
        push_exp(2'b01, 1'b0, 7'd1, 8'h5A);
        wait_idle("err_then_valid");
        chk("err_ngrants", 32'(ack_cyc_q.size()), 32'd2);
        if (ack_cyc_q.size() == 2) chk("err_regrant_delay", 32'(ack_cyc_q[1] - ack_cyc_q[0]), 32'(GAP));

        // Reset in the middle of SHIFT (bit 8): frame dropped, nCS high at once.
        push_tx(0, 7'd3, 8'h3C);
        gq.push_back('{2'b01, 1'b0});
        t = 0;
        hit = 1'b0;
        while (!hit && t < 60) begin
            @(negedge SCLK); #1; t++;
            hit = (mon_low == 10) && (nCS === 1'b0);
        end
        if (!hit) fail("shift_bit8_timeout", 32'(t), 32'd60);
        rst_n = 1'b0;
        #1;
        chk("midrst_ncs", 32'(nCS), 32'd1);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge SCLK);
        #1; rst_n = 1'b1;
        fq.delete();
        push_tx(1, 7'd4, 8'h96);
        push_exp(2'b10, 1'b0, 7'd4, 8'h96);
        wait_idle("post_reset");
        chk("post_reset_reg4", 32'(regs[4]), 32'h96);

        // Both requesters held for four frames: grants alternate with a fixed gap.
        gaps_q.delete();
        push_tx(0, 7'd0, 8'hC1); push_tx(0, 7'd2, 8'hC3);
        push_tx(1, 7'd1, 8'hC2); push_tx(1, 7'd3, 8'hC4);
        push_exp(2'b01, 1'b0, 7'd0, 8'hC1);
        push_exp(2'b10, 1'b0, 7'd1, 8'hC2);
        push_exp(2'b01, 1'b0, 7'd2, 8'hC3);
        push_exp(2'b10, 1'b0, 7'd3, 8'hC4);
        wait_idle("alternate");
        chk("alt_nframes", 32'(gaps_q.size()), 32'd4);
        for (int i = 1; i < gaps_q.size(); i++) chk("alt_gap", 32'(gaps_q[i]), 32'(GAP + 1));

        chk("left_grants", 32'(gq.size()), 32'd0);
        chk("left_frames", 32'(fq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
